// File: rtl/ysyx_23060236_div_ctrl_pkg.sv
// ysyx_23060236_div_ctrl_pkg: op encodings, FSM states and constants shared by the divide controller
package ysyx_23060236_div_ctrl_pkg;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL1    = 32'hFFFF_FFFF;
endpackage

// File: rtl/ysyx_23060236_div_ctrl_special.sv
// ysyx_23060236_div_special: RV32M divide-by-zero and signed-overflow results, resolved without the divider
module ysyx_23060236_div_special
  import ysyx_23060236_div_ctrl_pkg::*;
(
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        sign_i,
  output logic        is_special_o,
  output logic [31:0] q_o,
  output logic [31:0] r_o
);
  logic dz, ovf;
  assign dz = src2_i == '0;
  assign ovf = sign_i & (src1_i == INT_MIN) & (src2_i == ALL1);
  assign is_special_o = dz | ovf;
  // Divide-by-zero wins over overflow.
  assign q_o = dz ? ALL1 : INT_MIN;
  assign r_o = dz ? src1_i : '0;
endmodule

// File: rtl/ysyx_23060236_div_ctrl.sv
// ysyx_23060236_div_ctrl: sequences EXU divide ops onto the iterative divider with special-case and last-result cache
module ysyx_23060236_div_ctrl
  import ysyx_23060236_div_ctrl_pkg::*;
#(
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  output logic             div_valid,
  input  logic             div_ready,
  output logic             div_sign,
  output logic [31:0]      div1,
  output logic [31:0]      div2,
  input  logic [31:0]      div_res,
  input  logic [31:0]      div_rem,
  input  logic             div_outvalid
);
  logic [2:0] state_q, state_d;
  logic rem_q, sign_q, cvalid_q, csign_q;
  logic [31:0] src1_q, src2_q, res_q, c1_q, c2_q, cq_q, cr_q;
  logic [TAG_W-1:0] tag_q;
  logic in_sign, accept, is_special, hit, capture;
  logic [31:0] sp_q, sp_r, fast_res;
  assign in_sign = ~in_op[0];
  assign in_ready = (state_q == S_IDLE) & ~flush;
  assign accept = in_valid & in_ready;
  assign capture = (state_q == S_WAIT) & div_outvalid;
  ysyx_23060236_div_special u_special (
    .src1_i      (in_src1),
    .src2_i      (in_src2),
    .sign_i      (in_sign),
    .is_special_o(is_special),
    .q_o         (sp_q),
    .r_o         (sp_r)
  );
  assign hit = CACHE_EN & cvalid_q & (in_src1 == c1_q) & (in_src2 == c2_q) & (in_sign == csign_q);
  assign fast_res = is_special ? (in_op[1] ? sp_r : sp_q) : (in_op[1] ? cr_q : cq_q);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (is_special | hit) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = div_ready ? (flush ? S_DRAIN : S_WAIT) : (flush ? S_IDLE : S_ISSUE);
      S_WAIT:  state_d = div_outvalid ? (flush ? S_IDLE : S_DONE) : (flush ? S_DRAIN : S_WAIT);
      S_DONE:  if (flush | out_ready) state_d = S_IDLE;
      S_DRAIN: if (div_outvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // A completion that races a flush still refreshes the cache; only the result is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) cvalid_q <= 1'b1;
    end
    if (accept) begin
      rem_q  <= in_op[1];
      sign_q <= in_sign;
      src1_q <= in_src1;
      src2_q <= in_src2;
      tag_q  <= in_tag;
      res_q  <= fast_res;
    end
    if (capture) begin
      c1_q    <= src1_q;
      c2_q    <= src2_q;
      csign_q <= sign_q;
      cq_q    <= div_res;
      cr_q    <= div_rem;
      res_q   <= rem_q ? div_rem : div_res;
    end
  end
  assign out_valid = state_q == S_DONE;
  assign out_data = res_q;
  assign out_tag = tag_q;
  assign div_valid = state_q == S_ISSUE;
  assign div_sign = sign_q;
  assign div1 = src1_q;
  assign div2 = src2_q;
endmodule
